// File: rtl/rah_pkg.sv
// Shared RAH transmit-path constants and the packer state encoding.
`default_nettype none

package rah_pkg;

   localparam int RAH_PACKET_WIDTH = 48;
   localparam int MIPI_DATA_WIDTH  = 64;
   localparam int FILL_WIDTH       = $clog2(MIPI_DATA_WIDTH) + 1;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } pack_state_t;

endpackage

`default_nettype wire

// File: rtl/rah_tx_packer.sv
// 48-to-64 bit LSB-first gearbox: packs RAH packets into MIPI TX words and
// pads the tail of each burst.
`default_nettype none

module rah_tx_packer
   import rah_pkg::*;
#(
   parameter int   IN_WIDTH  = RAH_PACKET_WIDTH,
   parameter int   OUT_WIDTH = MIPI_DATA_WIDTH,
   parameter logic PAD_VALUE = 1'b0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [IN_WIDTH-1:0]          in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_WIDTH-1:0]         out_data,
   output logic                         out_last,
   output logic [$clog2(OUT_WIDTH):0]   fill_level
);

   localparam int FW = $clog2(OUT_WIDTH) + 1;

   pack_state_t                       state;
   logic [OUT_WIDTH-1:0]              residue;
   logic [OUT_WIDTH+IN_WIDTH-1:0]     combined;
   logic [FW-1:0]                     total;
   logic [FW-1:0]                     remain;
   logic                              word_full;
   logic                              accept;
   logic                              out_free;

   // Residue bits above fill_level are always zero, so OR-ing in the shifted
   // word appends it directly above the held bits.
   assign combined  = {{IN_WIDTH{1'b0}}, residue} | ({{OUT_WIDTH{1'b0}}, in_data} << fill_level);
   assign total     = fill_level + FW'(IN_WIDTH);
   assign word_full = total >= FW'(OUT_WIDTH);
   assign remain    = total - FW'(OUT_WIDTH);
   assign out_free  = !out_valid || out_ready;
   assign in_ready  = (state == RUN) && out_free;
   assign accept    = in_valid && in_ready;

   function automatic logic [OUT_WIDTH-1:0] pad_word(input logic [OUT_WIDTH-1:0] data,
                                                     input logic [FW-1:0]        nbits);
      logic [OUT_WIDTH-1:0] w;
      w = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         w[i] = (i < int'(nbits)) ? data[i] : PAD_VALUE;
      end
      return w;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         residue    <= '0;
         fill_level <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         out_data   <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            RUN: begin
               if (accept) begin
                  if (word_full) begin
                     out_data   <= combined[OUT_WIDTH-1:0];
                     out_valid  <= 1'b1;
                     residue    <= OUT_WIDTH'(combined >> OUT_WIDTH);
                     fill_level <= remain;
                     out_last   <= in_last && (remain == '0);
                     if (in_last && (remain != '0)) begin
                        state <= FLUSH;
                     end
                  end else if (in_last) begin
                     // Short burst tail: pad and close the burst in one word.
                     out_data   <= pad_word(combined[OUT_WIDTH-1:0], total);
                     out_valid  <= 1'b1;
                     out_last   <= 1'b1;
                     residue    <= '0;
                     fill_level <= '0;
                  end else begin
                     residue    <= combined[OUT_WIDTH-1:0];
                     fill_level <= total;
                  end
               end
            end
            FLUSH: begin
               if (out_free) begin
                  out_data   <= pad_word(residue, fill_level);
                  out_valid  <= 1'b1;
                  out_last   <= 1'b1;
                  residue    <= '0;
                  fill_level <= '0;
                  state      <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rah_tx_packer.sv
// Bench for rah_tx_packer: bit-queue reference model plus directed literal checks.
`default_nettype none

module tb_rah_tx_packer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [47:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic        out_last;
   logic [6:0]  fill_level;

   rah_tx_packer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .fill_level (fill_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a plain bit queue carved into 64-bit words.
   logic        bitq[$];
   logic [64:0] expq[$];
   logic [64:0] log_q[$];
   int          burstq[$];
   int          burst_bits = 0;
   int          burst_words = 0;
   logic        prev_v = 1'b0;
   logic        prev_r = 1'b0;
   logic        prev_l = 1'b0;
   logic [63:0] prev_d = '0;

   always @(negedge clk) begin
      logic [63:0] w;
      logic [64:0] e;
      if (rst) begin
         bitq.delete();
         expq.delete();
         burstq.delete();
         burst_bits  = 0;
         burst_words = 0;
         prev_v      = 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", out_data, prev_d);
            chk("hold_last", 64'(out_last), 64'(prev_l));
         end
         if (out_valid && !out_ready) chk("in_ready_bp", 64'(in_ready), 64'd0);
         if (in_ready) chk("fill_model", 64'(fill_level), 64'(bitq.size()));
         if (out_valid && out_ready) begin
            log_q.push_back({out_last, out_data});
            if (expq.size() == 0) begin
               chk("unexpected_word", out_data, 64'hx);
            end else begin
               e = expq.pop_front();
               chk("model_data", out_data, e[63:0]);
               chk("model_last", 64'(out_last), 64'(e[64]));
            end
            burst_words++;
            if (out_last) begin
               if (burstq.size() > 0) chk("burst_words", 64'(burst_words), 64'(burstq.pop_front()));
               burst_words = 0;
            end
         end
         if (in_valid && in_ready) begin
            for (int i = 0; i < 48; i++) bitq.push_back(in_data[i]);
            burst_bits += 48;
            while (bitq.size() >= 64) begin
               for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
               expq.push_back({in_last && (bitq.size() == 0), w});
            end
            if (in_last) begin
               if (bitq.size() > 0) begin
                  w = '0;
                  for (int i = 0; bitq.size() > 0; i++) w[i] = bitq.pop_front();
                  expq.push_back({1'b1, w});
               end
               burstq.push_back((burst_bits + 63) / 64);
               burst_bits = 0;
            end
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = out_data;
         prev_l = out_last;
      end
   end

   logic rand_mode = 1'b0;

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 9) < 7);
   endtask

   task automatic send(input logic [47:0] d, input logic l);
      int   n;
      logic acc;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      do begin
         @(negedge clk);
         acc = in_ready;
         step();
         n++;
      end while (!acc && n < 300);
      if (!acc) chk("send_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 48'h5A5A_DEAD_BEEF;
   endtask

   task automatic wait_log(input int n);
      int k;
      k = 0;
      while (log_q.size() < n && k < 300) begin
         step();
         k++;
      end
      if (log_q.size() < n) chk("log_timeout", 64'(log_q.size()), 64'(n));
   endtask

   task automatic chk_log(input string name, input int idx, input logic [63:0] d, input logic l);
      if (log_q.size() > idx) begin
         chk({name, "_data"}, log_q[idx][63:0], d);
         chk({name, "_last"}, 64'(log_q[idx][64]), 64'(l));
      end else begin
         chk({name, "_missing"}, 64'(log_q.size()), 64'(idx + 1));
      end
   endtask

   localparam logic [47:0] W0 = 48'hA0A1A2A3A4A5;
   localparam logic [47:0] W1 = 48'hB0B1B2B3B4B5;
   localparam logic [47:0] W2 = 48'hC0C1C2C3C4C5;
   localparam logic [47:0] W3 = 48'hD0D1D2D3D4D5;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_fill", 64'(fill_level), 64'd0);
      rst = 1'b0;
      step();

      // Four-word burst, no backpressure
      log_q.delete();
      send(W0, 1'b0); chk("t1_fill0", 64'(fill_level), 64'd48);
      send(W1, 1'b0); chk("t1_fill1", 64'(fill_level), 64'd32);
      send(W2, 1'b0); chk("t1_fill2", 64'(fill_level), 64'd16);
      send(W3, 1'b1); chk("t1_fill3", 64'(fill_level), 64'd0);
      wait_log(3);
      chk_log("t1_w0", 0, 64'hB4B5A0A1A2A3A4A5, 1'b0);
      chk_log("t1_w1", 1, 64'hC2C3C4C5B0B1B2B3, 1'b0);
      chk_log("t1_w2", 2, 64'hD0D1D2D3D4D5C0C1, 1'b1);
      repeat (3) step();

      // Single word burst: padded, no FLUSH cycle
      log_q.delete();
      send(W0, 1'b1);
      chk("t2_fill", 64'(fill_level), 64'd0);
      chk("t2_no_flush", 64'(in_ready), 64'd1);
      wait_log(1);
      chk_log("t2_w0", 0, 64'h0000A0A1A2A3A4A5, 1'b1);
      repeat (3) step();

      // Two-word burst ending in FLUSH
      log_q.delete();
      send(W0, 1'b0);
      send(W1, 1'b1);
      chk("t3_flush_ready", 64'(in_ready), 64'd0);
      wait_log(2);
      chk_log("t3_w0", 0, 64'hB4B5A0A1A2A3A4A5, 1'b0);
      chk_log("t3_w1", 1, 64'h00000000B0B1B2B3, 1'b1);
      repeat (3) step();

      // Backpressure hold for five cycles
      log_q.delete();
      out_ready = 1'b0;
      send(W0, 1'b0);
      send(W1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t4_hold_ready", 64'(in_ready), 64'd0);
         chk("t4_hold_valid", 64'(out_valid), 64'd1);
         chk("t4_hold_data", out_data, 64'hB4B5A0A1A2A3A4A5);
         step();
      end
      out_ready = 1'b1;
      send(W2, 1'b0);
      send(W3, 1'b1);
      wait_log(3);
      chk_log("t4_w0", 0, 64'hB4B5A0A1A2A3A4A5, 1'b0);
      chk_log("t4_w1", 1, 64'hC2C3C4C5B0B1B2B3, 1'b0);
      chk_log("t4_w2", 2, 64'hD0D1D2D3D4D5C0C1, 1'b1);
      repeat (3) step();

      // Asynchronous reset mid-burst
      log_q.delete();
      send(W0, 1'b0);
      send(W1, 1'b0);
      chk("t5_fill", 64'(fill_level), 64'd32);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 64'(out_valid), 64'd0);
      chk("t5_rst_data", out_data, 64'd0);
      chk("t5_rst_last", 64'(out_last), 64'd0);
      chk("t5_rst_fill", 64'(fill_level), 64'd0);
      step();
      step();
      rst = 1'b0;
      step();
      log_q.delete();
      send(W2, 1'b1);
      wait_log(1);
      chk_log("t5_w0", 0, 64'h0000C0C1C2C3C4C5, 1'b1);
      repeat (3) step();

      // Random traffic against the model
      rand_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         send({$urandom(), 16'($urandom())}, (i == 999) || ($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 3) == 0) step();
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;
      repeat (20) step();
      chk("rand_drained", 64'(expq.size()), 64'd0);
      chk("rand_bursts_done", 64'(burstq.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
